// File: rtl/scrambler_pkg.sv
// Shared constants for the 802.11 OFDM data scrambler (x^7 + x^4 + 1).
package scrambler_pkg;
    localparam int TAP_HI    = 6;
    localparam int TAP_LO    = 3;
    localparam int LFSR_LEN  = 7;
    localparam int TAIL_BITS = 7;
endpackage

// File: rtl/scrambler_lfsr_step.sv
// Combinational WIDTH-step unroll of the scrambler LFSR; bit 0 is first in time.
module scrambler_lfsr_step
    import scrambler_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [LFSR_LEN-1:0] state,
    input  logic [WIDTH-1:0]    data,
    output logic [WIDTH-1:0]    scrambled,
    output logic [LFSR_LEN-1:0] next_state
);

    logic [LFSR_LEN-1:0] chain [0:WIDTH];

    assign chain[0] = state;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic fb;
        assign fb           = chain[i][TAP_HI] ^ chain[i][TAP_LO];
        assign scrambled[i] = data[i] ^ fb;
        assign chain[i+1]   = {chain[i][LFSR_LEN-2:0], fb};
    end

    assign next_state = chain[WIDTH];

endmodule

// File: rtl/scrambler.sv
// AXI4-Stream bit scrambler: one registered output stage, LFSR reseeded after every tlast beat.
module scrambler
    import scrambler_pkg::*;
#(
    parameter int                  WIDTH = 24,
    parameter logic [LFSR_LEN-1:0] SEED  = 7'b1011101
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic [3:0]       s_axis_tuser,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [3:0]       m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    logic [LFSR_LEN-1:0] lfsr_q;
    logic [LFSR_LEN-1:0] lfsr_next;
    logic [WIDTH-1:0]    scr_data;
    logic                accept;

    logic [WIDTH-1:0]    data_p1;
    logic [3:0]          user_p1;
    logic                last_p1;
    logic                vld_p1;

    // The encoder needs the tail of each packet flushed with zeros.
    function automatic logic [WIDTH-1:0] zero_tail(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        r[WIDTH-1 -: TAIL_BITS] = '0;
        return r;
    endfunction

    scrambler_lfsr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .state      (lfsr_q),
        .data       (s_axis_tdata),
        .scrambled  (scr_data),
        .next_state (lfsr_next)
    );

    assign s_axis_tready = !vld_p1 || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Stage p0 -> p1: scramble on accept, hold while stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_q  <= SEED;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            user_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (accept) begin
            lfsr_q  <= s_axis_tlast ? SEED : lfsr_next;
            vld_p1  <= 1'b1;
            data_p1 <= s_axis_tlast ? zero_tail(scr_data) : scr_data;
            user_p1 <= s_axis_tuser;
            last_p1 <= s_axis_tlast;
        end else if (m_axis_tready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign m_axis_tdata  = data_p1;
    assign m_axis_tuser  = user_p1;
    assign m_axis_tlast  = last_p1;
    assign m_axis_tvalid = vld_p1;

endmodule

// File: tb/tb_scrambler.sv
// Directed bench for scrambler with a bit-serial reference model feeding a scoreboard queue.
module tb_scrambler;

    localparam int         WIDTH = 24;
    localparam logic [6:0] SEED  = 7'b1011101;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [3:0]       user;
        logic             last;
    } beat_t;

    logic             aclk;
    logic             aresetn;
    logic [WIDTH-1:0] s_axis_tdata;
    logic [3:0]       s_axis_tuser;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [WIDTH-1:0] m_axis_tdata;
    logic [3:0]       m_axis_tuser;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;

    int n_cmp  = 0;
    int n_fail = 0;

    beat_t exp_q [$];
    beat_t log_q [$];
    logic [6:0] model_s;

    scrambler #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: one LFSR step per bit, tail cleared and state reseeded on last.
    task automatic model_push(input logic [WIDTH-1:0] d, input logic [3:0] u, input logic l);
        beat_t e;
        logic  fb;
        e.data = d;
        e.user = u;
        e.last = l;
        for (int i = 0; i < WIDTH; i++) begin
            fb        = model_s[6] ^ model_s[3];
            e.data[i] = d[i] ^ fb;
            model_s   = {model_s[5:0], fb};
        end
        if (l) begin
            for (int i = WIDTH - 7; i < WIDTH; i++) e.data[i] = 1'b0;
            model_s = SEED;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are sampled on the falling edge; inputs only change just after rising edges.
    always @(negedge aclk) begin
        beat_t e;
        beat_t g;
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            g.data = m_axis_tdata;
            g.user = m_axis_tuser;
            g.last = m_axis_tlast;
            log_q.push_back(g);
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(g.data), 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_tdata", 32'(g.data), 32'(e.data));
                chk("sb_tuser", 32'(g.user), 32'(e.user));
                chk("sb_tlast", 32'(g.last), 32'(e.last));
            end
        end
    end

    task automatic drive(input logic [WIDTH-1:0] d, input logic [3:0] u, input logic l);
        @(posedge aclk);
        #2;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
    endtask

    task automatic wait_accept();
        int  cyc;
        logic done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 50) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                model_push(s_axis_tdata, s_axis_tuser, s_axis_tlast);
                @(posedge aclk);
                #2;
                s_axis_tvalid = 1'b0;
                done = 1'b1;
            end
            cyc++;
        end
        if (!done) chk("accept_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [3:0] u, input logic l);
        drive(d, u, l);
        wait_accept();
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge aclk);
            cyc++;
        end
        @(negedge aclk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int         base;
        beat_t      held;
        logic [WIDTH-1:0] rd;

        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        model_s       = SEED;

        // Reset state
        #13;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
        chk("rst_tuser",  32'(m_axis_tuser),  32'd0);
        chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_tready", 32'(s_axis_tready), 32'd1);

        // Sequence test: zero beats expose the raw keystream
        base = log_q.size();
        for (int i = 0; i < 3; i++) send('0, 4'(i), 1'b0);
        drain();
        chk("seq_beat0_lo16", 32'(log_q[base].data[15:0]), 32'h0000_9836);
        chk("seq_user2", 32'(log_q[base+2].user), 32'd2);

        // Data test: arbitrary beats continuing the sequence
        for (int i = 0; i < 10; i++) begin
            rd = WIDTH'($urandom);
            send(rd, 4'(i), 1'b0);
        end
        drain();

        // Tlast test
        base = log_q.size();
        send(24'hA5C3F0, 4'hA, 1'b0);
        send(24'hFFFFFF, 4'hB, 1'b1);
        drain();
        chk("tlast_tail_zero", 32'(log_q[base+1].data[WIDTH-1:WIDTH-7]), 32'd0);
        chk("tlast_flag", 32'(log_q[base+1].last), 32'd1);

        // Reseed test
        base = log_q.size();
        send('0, 4'h3, 1'b0);
        drain();
        chk("reseed_lo16", 32'(log_q[base].data[15:0]), 32'h0000_9836);

        // Backpressure test
        base = log_q.size();
        @(posedge aclk);
        #2;
        m_axis_tready = 1'b0;
        send(24'h123456, 4'h4, 1'b0);
        @(negedge aclk);
        held.data = m_axis_tdata;
        held.user = m_axis_tuser;
        held.last = m_axis_tlast;
        drive(24'h654321, 4'h5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_tready_low", 32'(s_axis_tready), 32'd0);
            chk("bp_hold_tdata", 32'(m_axis_tdata), 32'(held.data));
            chk("bp_hold_valid", 32'(m_axis_tvalid), 32'd1);
        end
        @(posedge aclk);
        #2;
        m_axis_tready = 1'b1;
        wait_accept();
        send(24'h0F0F0F, 4'h6, 1'b1);
        drain();
        chk("bp_beat_count", 32'(log_q.size() - base), 32'd3);

        // Reset test: abort mid-packet while output is held
        @(posedge aclk);
        #2;
        m_axis_tready = 1'b0;
        send(24'hDEADBE, 4'h7, 1'b0);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_valid_drop", 32'(m_axis_tvalid), 32'd0);
        exp_q.delete();
        model_s = SEED;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        base = log_q.size();
        send('0, 4'h8, 1'b0);
        drain();
        chk("arst_restart_lo16", 32'(log_q[base].data[15:0]), 32'h0000_9836);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
